// File: rtl/i2c_arbiter_pkg.sv
// Shared state encoding and width helper for the shared-bus I2C arbiter.
package i2c_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // $clog2 with a one-bit floor so degenerate parameters still give legal vectors.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin pick: first eligible index after 'last', wrapping at N.
module round_robin_select
    import i2c_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [2*N-1:0] doubled;
    logic [IW:0]    shift;
    logic [N-1:0]   rotated;
    logic [N-1:0]   first_hot;
    logic [IW-1:0]  offset;
    logic [IW:0]    sum;

    assign doubled = {eligible, eligible};
    assign shift   = {1'b0, last} + (IW+1)'(1);

    // Bit k of rotated is channel (last + 1 + k) mod N, so its lowest set bit is next in turn.
    assign rotated   = N'(doubled >> shift);
    assign first_hot = rotated & (~rotated + N'(1));
    assign valid     = |eligible;

    for (genvar gb = 0; gb < IW; gb++) begin : g_encode
        logic [N-1:0] mask;
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign mask[gi] = ((gi >> gb) & 1) == 1;
        end
        assign offset[gb] = |(first_hot & mask);
    end

    assign sum    = {1'b0, last} + (IW+1)'(1) + {1'b0, offset};
    assign winner = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C bus between several channels: round-robin grant, bus-free gap, hang watchdog.
module i2c_bus_arbiter
    import i2c_arbiter_pkg::*;
#(
    parameter int CHANNEL_COUNT  = 2,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 20_000_000
) (
    input  logic                                 system_clock,
    input  logic                                 system_reset,
    input  logic [CHANNEL_COUNT-1:0]             request,
    output logic [CHANNEL_COUNT-1:0]             grant,
    input  logic [CHANNEL_COUNT-1:0]             client_scl_output,
    input  logic [CHANNEL_COUNT-1:0]             client_sda_output,
    output logic [CHANNEL_COUNT-1:0]             client_scl_input,
    output logic [CHANNEL_COUNT-1:0]             client_sda_input,
    input  logic                                 scl_input,
    input  logic                                 sda_input,
    output logic                                 scl_output,
    output logic                                 sda_output,
    output logic [clog2_min1(CHANNEL_COUNT)-1:0] owner,
    output logic                                 busy,
    output logic                                 timeout_pulse
);

    localparam int IW = clog2_min1(CHANNEL_COUNT);
    localparam int TW = clog2_min1(TIMEOUT_CYCLES);
    localparam int GW = clog2_min1(GAP_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_INIT  = IW'(CHANNEL_COUNT - 1);

    arb_state_t               state_reg, state_next;
    logic [CHANNEL_COUNT-1:0] grant_reg, grant_next;
    logic [CHANNEL_COUNT-1:0] lockout_reg, lockout_next;
    logic [IW-1:0]            owner_reg, owner_next;
    logic [IW-1:0]            last_reg, last_next;
    logic [TW-1:0]            timer_reg, timer_next;
    logic [GW-1:0]            gap_reg, gap_next;
    logic                     scl_reg, scl_next;
    logic                     sda_reg, sda_next;
    logic                     timeout_reg, timeout_next;

    logic [CHANNEL_COUNT-1:0] eligible;
    logic [IW-1:0]            winner;
    logic                     winner_valid;
    logic [CHANNEL_COUNT-1:0] winner_onehot;
    logic                     owner_request;
    logic                     owner_scl;
    logic                     owner_sda;
    logic                     bus_high;

    for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_broadcast
        assign client_scl_input[gi] = scl_input;
        assign client_sda_input[gi] = sda_input;
    end

    assign eligible = request & ~lockout_reg;

    round_robin_select #(
        .N  (CHANNEL_COUNT),
        .IW (IW)
    ) u_select (
        .eligible (eligible),
        .last     (last_reg),
        .winner   (winner),
        .valid    (winner_valid)
    );

    // grant_reg is one-hot while owned, so masking with it selects the owner without an index mux.
    assign winner_onehot = CHANNEL_COUNT'(1) << winner;
    assign owner_request = |(request & grant_reg);
    assign owner_scl     = ~|(~client_scl_output & grant_reg);
    assign owner_sda     = ~|(~client_sda_output & grant_reg);
    assign bus_high      = scl_input & sda_input;

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            lockout_reg <= '0;
            owner_reg   <= '0;
            last_reg    <= LAST_INIT;
            timer_reg   <= '0;
            gap_reg     <= '0;
            scl_reg     <= 1'b1;
            sda_reg     <= 1'b1;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            lockout_reg <= lockout_next;
            owner_reg   <= owner_next;
            last_reg    <= last_next;
            timer_reg   <= timer_next;
            gap_reg     <= gap_next;
            scl_reg     <= scl_next;
            sda_reg     <= sda_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        owner_next   = owner_reg;
        last_next    = last_reg;
        timer_next   = timer_reg;
        gap_next     = gap_reg;
        lockout_next = lockout_reg & request;
        timeout_next = 1'b0;
        scl_next     = 1'b1;
        sda_next     = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (winner_valid) begin
                    state_next = ST_GRANT;
                    grant_next = winner_onehot;
                    owner_next = winner;
                    last_next  = winner;
                    timer_next = '0;
                end
            end
            ST_GRANT: begin
                timer_next = timer_reg + TW'(1);
                scl_next   = owner_scl;
                sda_next   = owner_sda;
                // A voluntary release takes precedence over a coincident watchdog expiry.
                if (!owner_request) begin
                    state_next = ST_GAP;
                    grant_next = '0;
                    gap_next   = '0;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next   = ST_GAP;
                    grant_next   = '0;
                    gap_next     = '0;
                    timeout_next = 1'b1;
                    lockout_next = lockout_next | grant_reg;
                end
            end
            ST_GAP: begin
                if (!bus_high) begin
                    gap_next = '0;
                end else if (gap_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
            end
        endcase
    end

    assign grant         = grant_reg;
    assign owner         = owner_reg;
    assign busy          = (state_reg == ST_GRANT);
    assign scl_output    = scl_reg;
    assign sda_output    = sda_reg;
    assign timeout_pulse = timeout_reg;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: scripted scenarios plus random traffic against a cycle reference model.
module tb_i2c_bus_arbiter;

    localparam int N   = 2;
    localparam int GAP = 4;
    localparam int TMO = 16;

    logic         system_clock = 1'b0;
    logic         system_reset;
    logic [N-1:0] request;
    logic [N-1:0] grant;
    logic [N-1:0] client_scl_output;
    logic [N-1:0] client_sda_output;
    logic [N-1:0] client_scl_input;
    logic [N-1:0] client_sda_input;
    logic         scl_input;
    logic         sda_input;
    logic         scl_output;
    logic         sda_output;
    logic [0:0]   owner;
    logic         busy;
    logic         timeout_pulse;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: who owns the bus (-1 = nobody), rotation pointer, quiet-bus count, lockouts.
    int       m_owner;
    int       m_last;
    int       m_owner_out;
    int       m_hold;
    int       m_quiet;
    bit       m_gap;
    bit       m_pulse;
    bit       m_scl;
    bit       m_sda;
    bit [N-1:0] m_lock;

    always #5 system_clock = ~system_clock;

    i2c_bus_arbiter #(
        .CHANNEL_COUNT  (N),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .system_clock      (system_clock),
        .system_reset      (system_reset),
        .request           (request),
        .grant             (grant),
        .client_scl_output (client_scl_output),
        .client_sda_output (client_sda_output),
        .client_scl_input  (client_scl_input),
        .client_sda_input  (client_sda_input),
        .scl_input         (scl_input),
        .sda_input         (sda_input),
        .scl_output        (scl_output),
        .sda_output        (sda_output),
        .owner             (owner),
        .busy              (busy),
        .timeout_pulse     (timeout_pulse)
    );

    task automatic model_reset();
        m_owner     = -1;
        m_last      = N - 1;
        m_owner_out = 0;
        m_hold      = 0;
        m_quiet     = 0;
        m_gap       = 1'b0;
        m_pulse     = 1'b0;
        m_scl       = 1'b1;
        m_sda       = 1'b1;
        m_lock      = '0;
    endtask

    // Advance the model by one clock using the inputs currently applied to the DUT.
    task automatic model_step();
        bit [N-1:0] next_lock;
        next_lock = m_lock & request;
        m_pulse   = 1'b0;
        m_scl     = 1'b1;
        m_sda     = 1'b1;
        if (m_owner >= 0) begin
            m_scl  = bit'((client_scl_output >> m_owner) & 1);
            m_sda  = bit'((client_sda_output >> m_owner) & 1);
            m_hold = m_hold + 1;
            if (((request >> m_owner) & 1) == 0) begin
                m_owner = -1;
                m_gap   = 1'b1;
                m_quiet = 0;
            end else if (m_hold == TMO) begin
                next_lock = next_lock | (N'(1) << m_owner);
                m_pulse   = 1'b1;
                m_owner   = -1;
                m_gap     = 1'b1;
                m_quiet   = 0;
            end
        end else if (m_gap) begin
            if (scl_input === 1'b1 && sda_input === 1'b1) begin
                m_quiet = m_quiet + 1;
                if (m_quiet == GAP) m_gap = 1'b0;
            end else begin
                m_quiet = 0;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (m_owner < 0 && ((request >> c) & 1) == 1 && ((m_lock >> c) & 1) == 0) begin
                    m_owner     = c;
                    m_last      = c;
                    m_owner_out = c;
                    m_hold      = 0;
                    $display("[%0t] grant -> channel %0d", $time, c);
                end
            end
        end
        m_lock = next_lock;
    endtask

    function automatic logic [6:0] exp_vec();
        logic [1:0] g;
        g = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        return {g, 1'(m_owner >= 0), 1'(m_owner_out), m_scl, m_sda, m_pulse};
    endfunction

    task automatic tick();
        model_step();
        @(posedge system_clock);
        #1;
    endtask

    task automatic test_reset();
        system_reset      = 1'b1;
        request           = '0;
        client_scl_output = '1;
        client_sda_output = '1;
        scl_input         = 1'b1;
        sda_input         = 1'b1;
        model_reset();
        repeat (2) @(posedge system_clock);
        #1;
        compared++;
        if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== 7'b0000110) begin
            mismatched++;
            $display("FAIL reset_state: got %b want %b",
                     {grant, busy, owner, scl_output, sda_output, timeout_pulse}, 7'b0000110);
        end
        scl_input = 1'b0;
        #1;
        compared++;
        if ({client_scl_input, client_sda_input} !== 4'b0011) begin
            mismatched++;
            $display("FAIL broadcast_scl: got %b want %b", {client_scl_input, client_sda_input}, 4'b0011);
        end
        scl_input = 1'b1;
        sda_input = 1'b0;
        #1;
        compared++;
        if ({client_scl_input, client_sda_input} !== 4'b1100) begin
            mismatched++;
            $display("FAIL broadcast_sda: got %b want %b", {client_scl_input, client_sda_input}, 4'b1100);
        end
        sda_input    = 1'b1;
        system_reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic_grant();
        bit v_scl;
        bit v_sda;
        request = 2'b01;
        tick();
        compared++;
        if (grant !== 2'b01 || owner !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL first_grant: got grant=%b owner=%b busy=%b want 01/0/1", grant, owner, busy);
        end
        for (int i = 0; i < 8; i++) begin
            v_scl = 1'($urandom_range(0, 1));
            v_sda = 1'($urandom_range(0, 1));
            client_scl_output = {1'($urandom_range(0, 1)), v_scl};
            client_sda_output = {1'($urandom_range(0, 1)), v_sda};
            tick();
            compared++;
            if (scl_output !== v_scl || sda_output !== v_sda) begin
                mismatched++;
                $display("FAIL owner_drive: got scl=%b sda=%b want scl=%b sda=%b", scl_output, sda_output, v_scl, v_sda);
            end
            compared++;
            if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== exp_vec()) begin
                mismatched++;
                $display("FAIL basic_cycle: got %b want %b",
                         {grant, busy, owner, scl_output, sda_output, timeout_pulse}, exp_vec());
            end
        end
        request           = '0;
        client_scl_output = '1;
        client_sda_output = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            compared++;
            if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== exp_vec()) begin
                mismatched++;
                $display("FAIL basic_release: got %b want %b",
                         {grant, busy, owner, scl_output, sda_output, timeout_pulse}, exp_vec());
            end
        end
        $display("test_basic_grant done");
    endtask

    task automatic test_alternation();
        int         seq[$];
        int         zeros = 0;
        logic [1:0] prev  = 2'b00;
        request = 2'b01;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 1)  request = 2'b11;
            if (cyc == 4)  request = 2'b10;
            if (cyc == 6)  request = 2'b11;
            if (cyc == 14) request = 2'b01;
            if (cyc == 25) request = 2'b00;
            tick();
            compared++;
            if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== exp_vec()) begin
                mismatched++;
                $display("FAIL alternation_cycle %0d: got %b want %b", cyc,
                         {grant, busy, owner, scl_output, sda_output, timeout_pulse}, exp_vec());
            end
            if (grant !== 2'b00 && grant !== prev) begin
                if (seq.size() > 0) begin
                    compared++;
                    if (zeros != GAP + 1) begin
                        mismatched++;
                        $display("FAIL gap_length: got %0d idle cycles want %0d", zeros, GAP + 1);
                    end
                end
                seq.push_back((grant === 2'b10) ? 1 : 0);
            end
            zeros = (grant === 2'b00) ? zeros + 1 : 0;
            prev  = grant;
        end
        compared++;
        if (seq.size() != 3 || seq[0] != 0 || seq[1] != 1 || seq[2] != 0) begin
            mismatched++;
            $display("FAIL alternation_order: got %0d grants (%p) want 0,1,0", seq.size(), seq);
        end
        $display("test_alternation done");
    endtask

    task automatic test_timeout();
        int granted = 0;
        int pulses  = 0;
        request = 2'b10;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 26) request = 2'b00;
            if (cyc == 27) request = 2'b10;
            if (cyc == 34) request = 2'b00;
            tick();
            compared++;
            if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== exp_vec()) begin
                mismatched++;
                $display("FAIL timeout_cycle %0d: got %b want %b", cyc,
                         {grant, busy, owner, scl_output, sda_output, timeout_pulse}, exp_vec());
            end
            if (cyc < 26) begin
                granted += (grant === 2'b10) ? 1 : 0;
                pulses  += (timeout_pulse === 1'b1) ? 1 : 0;
            end
            if (cyc == 27) begin
                compared++;
                if (grant !== 2'b10) begin
                    mismatched++;
                    $display("FAIL timeout_regrant: got %b want 10", grant);
                end
            end
        end
        compared++;
        if (granted != TMO) begin
            mismatched++;
            $display("FAIL timeout_hold: got %0d granted cycles want %0d", granted, TMO);
        end
        compared++;
        if (pulses != 1) begin
            mismatched++;
            $display("FAIL timeout_pulse_count: got %0d want 1", pulses);
        end
        $display("test_timeout done");
    endtask

    task automatic test_gap_glitch();
        int first = -1;
        request = 2'b01;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc == 3) request = 2'b00;
            if (cyc == 5) begin
                request   = 2'b01;
                sda_input = 1'b0;
            end
            if (cyc == 8) sda_input = 1'b1;
            tick();
            compared++;
            if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== exp_vec()) begin
                mismatched++;
                $display("FAIL glitch_cycle %0d: got %b want %b", cyc,
                         {grant, busy, owner, scl_output, sda_output, timeout_pulse}, exp_vec());
            end
            if (cyc > 3 && first < 0 && grant !== 2'b00) first = cyc;
        end
        compared++;
        if (first != 12) begin
            mismatched++;
            $display("FAIL gap_restart: got regrant at cycle %0d want 12", first);
        end
        $display("test_gap_glitch done");
    endtask

    task automatic test_drop_at_timeout();
        int granted = 0;
        int pulses  = 0;
        request = 2'b10;
        for (int cyc = 0; cyc < 28; cyc++) begin
            if (cyc == 16) request = 2'b00;
            if (cyc == 17) request = 2'b10;
            tick();
            compared++;
            if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== exp_vec()) begin
                mismatched++;
                $display("FAIL drop_cycle %0d: got %b want %b", cyc,
                         {grant, busy, owner, scl_output, sda_output, timeout_pulse}, exp_vec());
            end
            pulses += (timeout_pulse === 1'b1) ? 1 : 0;
            if (cyc < 16) granted += (grant === 2'b10) ? 1 : 0;
            if (cyc == 21) begin
                compared++;
                if (grant !== 2'b10) begin
                    mismatched++;
                    $display("FAIL drop_regrant: got %b want 10", grant);
                end
            end
        end
        compared++;
        if (pulses != 0 || granted != TMO) begin
            mismatched++;
            $display("FAIL drop_wins: got pulses=%0d held=%0d want 0/%0d", pulses, granted, TMO);
        end
        $display("test_drop_at_timeout done");
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 7) == 0) request = request ^ 2'b01;
            if ($urandom_range(0, 7) == 0) request = request ^ 2'b10;
            client_scl_output = 2'($urandom);
            client_sda_output = 2'($urandom);
            scl_input = 1'($urandom_range(0, 9) != 0);
            sda_input = 1'($urandom_range(0, 9) != 0);
            tick();
            compared++;
            if ({grant, busy, owner, scl_output, sda_output, timeout_pulse} !== exp_vec()) begin
                mismatched++;
                $display("FAIL random_cycle %0d: got %b want %b", cyc,
                         {grant, busy, owner, scl_output, sda_output, timeout_pulse}, exp_vec());
            end
        end
        $display("test_random done");
    endtask

    task automatic test_reset_midtransfer();
        request           = 2'b01;
        client_scl_output = 2'b10;
        client_sda_output = 2'b10;
        repeat (3) tick();
        compared++;
        if (grant !== 2'b01 || scl_output !== 1'b0 || sda_output !== 1'b0) begin
            mismatched++;
            $display("FAIL pre_reset_drive: got grant=%b scl=%b sda=%b want 01/0/0", grant, scl_output, sda_output);
        end
        system_reset = 1'b1;
        #1;
        compared++;
        if ({grant, busy, scl_output, sda_output} !== 5'b00011) begin
            mismatched++;
            $display("FAIL async_reset: got %b want %b", {grant, busy, scl_output, sda_output}, 5'b00011);
        end
        model_reset();
        repeat (2) @(posedge system_clock);
        #1;
        system_reset      = 1'b0;
        client_scl_output = '1;
        client_sda_output = '1;
        request           = 2'b11;
        tick();
        compared++;
        if (grant !== 2'b01 || grant !== exp_vec()[6:5]) begin
            mismatched++;
            $display("FAIL post_reset_first: got %b want 01", grant);
        end
        $display("test_reset_midtransfer done");
    endtask

    task automatic settle();
        request           = '0;
        client_scl_output = '1;
        client_sda_output = '1;
        scl_input         = 1'b1;
        sda_input         = 1'b1;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_alternation();
        settle();
        test_timeout();
        settle();
        test_gap_glitch();
        settle();
        test_drop_at_timeout();
        settle();
        test_random();
        settle();
        test_reset_midtransfer();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within 200000 time units");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Lets CHANNEL_COUNT HDMI-out channels share one physical I2C bus (SCL/SDA through one IOBUF pair) via each channel's i2c_request/i2c_grant handshake.
- Arbitration is round-robin with a mandatory bus-free gap between owners and a watchdog that revokes a hung owner.
- Sits in the top level between the per-channel HDMI-out example instances and the shared SCL/SDA IOBUFs; replaces tying i2c_grant high.

Parameters:
CHANNEL_COUNT, 2, number of requesting channels (>=1)
GAP_CYCLES, 1000, cycles of bus-high idle required between owners (5 us at 200 MHz)
TIMEOUT_CYCLES, 20_000_000, maximum continuous ownership before forced revoke (100 ms at 200 MHz)

Ports:
system_clock  input  1  single clock domain
system_reset  input  1  asynchronous, active-high reset
request  input  CHANNEL_COUNT  per-channel i2c_request
grant  output  CHANNEL_COUNT  per-channel i2c_grant, one-hot or zero
client_scl_output  input  CHANNEL_COUNT  per-channel SCL drive (0 = pull low, 1 = release)
client_sda_output  input  CHANNEL_COUNT  per-channel SDA drive
client_scl_input  output  CHANNEL_COUNT  bus SCL broadcast to every channel
client_sda_input  output  CHANNEL_COUNT  bus SDA broadcast to every channel
scl_input  input  1  bus SCL from IOBUF O
sda_input  input  1  bus SDA from IOBUF O
scl_output  output  1  to IOBUF I and T (1 = release)
sda_output  output  1  to IOBUF I and T
owner  output  $clog2(CHANNEL_COUNT) or 1 minimum  index of current or last owner
busy  output  1  high in GRANT
timeout_pulse  output  1  one-cycle strobe on forced revoke

Behaviour:
- Reset values (async): state IDLE, grant 0, scl_output 1, sda_output 1, busy 0, timeout_pulse 0, owner 0, last pointer CHANNEL_COUNT-1 so channel 0 wins first, lockout 0, all counters 0.
- client_*_input are combinational broadcasts of scl_input/sda_input to all channels, regardless of state.
- scl_output/sda_output are registered.
  - In GRANT they equal the owner's client_*_output, delayed one cycle.
  - Otherwise both are 1.
- Eligible channel: request[i] & ~lockout[i].
- IDLE:
  - If any channel is eligible, pick the first eligible index scanning (last+1) mod N upward with wrap.
  - Next cycle: state GRANT, grant[w]=1, owner=w, last=w, timer=0.
  - Latency from request to grant is 1 cycle.
- GRANT:
  - busy=1; timer increments each cycle.
  - If request[owner]=0: grant 0 next cycle, go to GAP, gap counter 0.
  - Else if timer==TIMEOUT_CYCLES-1: grant 0 next cycle, timeout_pulse=1 for that cycle, lockout[owner]=1, go to GAP.
  - If request drop and timeout coincide, the drop wins: no pulse, no lockout.
- GAP:
  - Outputs released.
  - Gap counter increments only while scl_input & sda_input are both 1; any low sample resets it to 0.
  - When count reaches GAP_CYCLES-1 with both lines high, go to IDLE.
  - Requests arriving during GAP are held until IDLE; no grant is issued in GAP.
- Lockout:
  - lockout[i] clears on any cycle with request[i]=0.
  - A locked-out channel must deassert request before it can win again.
- Simultaneous requests: round-robin order only; no fixed priority except after reset.
- CHANNEL_COUNT=1: pointer logic degenerates; the single channel alternates GRANT and GAP.
- Reset mid-transfer: immediate release of both lines and grant 0; the client sees grant drop.
- Counter widths are $clog2 of the respective parameter, with a minimum of 1.

Decomposition:
- Package i2c_arbiter_pkg:
  - state encoding (IDLE, GRANT, GAP)
  - helper function for minimum-1 clog2 width
- Sub-module round_robin_select:
  - combinational, parameter N
  - inputs: eligible vector, last index
  - outputs: winner index, valid

Test Plan (bench uses CHANNEL_COUNT=2, GAP_CYCLES=4, TIMEOUT_CYCLES=16, bus lines pulled high unless stated):
- Reset, then request=01 -> grant=01 one cycle later; owner=0; busy=1; scl_output follows client_scl_output[0] with 1-cycle delay.
- request=11 held; ch0 drops request -> grant=00 for 4 gap cycles plus 1 cycle in IDLE, then grant=10; ch0 re-requests and gets grant only after ch1 releases (alternation 0,1,0).
- ch1 holds request 16 cycles -> grant drops; timeout_pulse=1 exactly once; ch1 not re-granted while request stays high; after ch1 deasserts for 1 cycle and reasserts, it is granted after the gap.
- GAP with sda_input forced low for 3 cycles mid-gap -> gap counter restarts; IDLE is reached only after 4 consecutive high cycles.
- request drop on the same cycle the timer hits 15 -> timeout_pulse stays 0 and no lockout.
- Assert system_reset while busy with client_sda_output[0]=0 -> same cycle: grant=00, sda_output=1, scl_output=1; after release, request=11 -> channel 0 wins first.
